// File: rtl/bcd_conv_arbiter.sv
// Two-requester round-robin front end for a serial double-dabble binary-to-BCD converter.
// Optional conversion counter output conv_cnt is enabled by defining BCD_ARB_STATS_EN.
module bcd_conv_arbiter #(
   parameter int N_BITS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [N_BITS-1:0] bin0,
   input  logic              req1,
   input  logic [N_BITS-1:0] bin1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              busy,
   output logic              done,
   output logic              done_id,
`ifdef BCD_ARB_STATS_EN
   output logic [7:0]        conv_cnt,
`endif
   output logic [11:0]       bcd_out
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   localparam int         W          = N_BITS + 12;
   localparam logic [3:0] LAST_SHIFT = 4'(N_BITS - 1);

   state_t        r_state;
   state_t        w_next;
   logic [W-1:0]  r_sh;
   logic [W-1:0]  w_shifted;
   logic [11:0]   w_adj;
   logic [11:0]   r_bcd;
   logic [3:0]    r_cnt;
   logic          r_id;
   logic          r_last;
   logic          r_gnt0;
   logic          r_gnt1;
   logic          r_done;
   logic          r_done_id;
   logic          w_take;
   logic          w_pick;
`ifdef BCD_ARB_STATS_EN
   logic [7:0]    r_conv_cnt;
`endif

   // On a tie the requester not served last wins; r_last resets to 1 so requester 0 wins first.
   always_comb begin
      w_take = req0 | req1;
      w_pick = (req0 && req1) ? ~r_last : req1;
   end

   // Add-3 correction on every BCD digit >= 5, then shift {bcd, operand} left by one.
   always_comb begin
      // NOTE: every always_comb target gets a default first so no path can infer a latch.
      w_adj = r_sh[W-1:N_BITS];
      for (int d = 0; d < 3; d++) begin
         if (w_adj[4*d +: 4] >= 4'd5) begin
            w_adj[4*d +: 4] = w_adj[4*d +: 4] + 4'd3;
         end
      end
      w_shifted = {w_adj[10:0], r_sh[N_BITS-1:0], 1'b0};
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_take) w_next = S_LOAD;
         S_LOAD:  w_next = S_SHIFT;
         S_SHIFT: if (r_cnt == LAST_SHIFT) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_state   <= S_IDLE;
         r_sh      <= '0;
         r_cnt     <= '0;
         r_id      <= 1'b0;
         r_last    <= 1'b1;
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_done    <= 1'b0;
         r_done_id <= 1'b0;
         r_bcd     <= 12'h000;
`ifdef BCD_ARB_STATS_EN
         r_conv_cnt <= 8'd0;
`endif
      end else begin
         r_state <= w_next;
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_done  <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_take) begin
                  r_id   <= w_pick;
                  r_last <= w_pick;
                  r_gnt0 <= ~w_pick;
                  r_gnt1 <= w_pick;
                  r_sh   <= {12'h000, (w_pick ? bin1 : bin0)};
                  r_cnt  <= '0;
               end
            end
            S_SHIFT: begin
               r_sh  <= w_shifted;
               r_cnt <= r_cnt + 4'd1;
            end
            S_DONE: begin
               r_bcd     <= r_sh[W-1:N_BITS];
               r_done_id <= r_id;
               r_done    <= 1'b1;
`ifdef BCD_ARB_STATS_EN
               r_conv_cnt <= r_conv_cnt + 8'd1;
`endif
            end
            default: ;
         endcase
      end
   end

   assign gnt0    = r_gnt0;
   assign gnt1    = r_gnt1;
   assign busy    = (r_state != S_IDLE);
   assign done    = r_done;
   assign done_id = r_done_id;
   assign bcd_out = r_bcd;
`ifdef BCD_ARB_STATS_EN
   assign conv_cnt = r_conv_cnt;
`endif

endmodule
